// File: rtl/receive_dut_if.sv
// Byte-stream receive port plus register access bus for receive_dut.
// clk and rst_n stay outside the interface as plain module ports.
interface receive_dut_if;
    logic       rx_en;
    logic [7:0] rx_data;
    logic [1:0] addr;
    logic [7:0] wr_data;
    logic       wr;
    logic       rd;
    logic [7:0] rd_data;
    logic       frame_done;

    modport master (
        output rx_en, rx_data, addr, wr_data, wr, rd,
        input  rd_data, frame_done
    );

    modport slave (
        input  rx_en, rx_data, addr, wr_data, wr, rd,
        output rd_data, frame_done
    );
endinterface

// File: rtl/receive_dut.sv
// Frame receiver: parses DE AD LEN payload BE EF from a byte stream into a buffer,
// exposes CTRL/STATUS/LEN/DATA registers for readout and error reporting.
module receive_dut #(
    parameter int MAX_LEN = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    receive_dut_if.slave bus
);

    localparam int PTR_W = 5;
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [7:0] SOF0      = 8'hDE;
    localparam logic [7:0] SOF1      = 8'hAD;
    localparam logic [7:0] EOF0      = 8'hBE;
    localparam logic [7:0] EOF1      = 8'hEF;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_LEN    = 2'd2;
    localparam logic [1:0] ADDR_DATA   = 2'd3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR1  = 3'd1;
    localparam logic [2:0] S_LENB  = 3'd2;
    localparam logic [2:0] S_PAYLD = 3'd3;
    localparam logic [2:0] S_TRL0  = 3'd4;
    localparam logic [2:0] S_TRL1  = 3'd5;

    logic [2:0]       state_q,      state_d;
    logic             en_q,         en_d;
    logic             clr_q,        clr_d;
    logic             valid_q,      valid_d;
    logic             err_trl_q,    err_trl_d;
    logic             err_len_q,    err_len_d;
    logic             err_gap_q,    err_gap_d;
    logic             ovf_q,        ovf_d;
    logic [PTR_W-1:0] len_q,        len_d;
    logic [PTR_W-1:0] rx_len_q,     rx_len_d;
    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic [7:0]       rd_data_q,    rd_data_d;
    logic             frame_done_q, frame_done_d;

    logic [7:0]    buffer [MAX_LEN];
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [7:0]    buf_rdata;
    logic [7:0]    status;
    logic [7:0]    len_ext;
    logic          unused_wr_bits;

    assign buf_waddr      = wr_ptr_q[AW-1:0];
    assign buf_rdata      = buffer[rd_ptr_q[AW-1:0]];
    assign status         = {3'b000, ovf_q, err_gap_q, err_len_q, err_trl_q, valid_q};
    assign len_ext        = {{(8 - PTR_W){1'b0}}, len_q};
    assign unused_wr_bits = ^bus.wr_data[7:2];

    assign bus.rd_data    = rd_data_q;
    assign bus.frame_done = frame_done_q;

    always_comb begin
        // NOTE: every next-state signal starts from a default so no path leaves a latch behind.
        state_d      = state_q;
        en_d         = en_q;
        clr_d        = 1'b0;
        valid_d      = valid_q;
        err_trl_d    = err_trl_q;
        err_len_d    = err_len_q;
        err_gap_d    = err_gap_q;
        ovf_d        = ovf_q;
        len_d        = len_q;
        rx_len_d     = rx_len_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_data_d    = rd_data_q;
        frame_done_d = 1'b0;
        buf_we       = 1'b0;

        if (bus.wr && bus.addr == ADDR_CTRL) begin
            en_d  = bus.wr_data[0];
            clr_d = bus.wr_data[1];
        end

        // Reads sample the pre-edge register values, so a same-cycle CTRL write is not visible.
        if (bus.rd) begin
            unique case (bus.addr)
                ADDR_CTRL:   rd_data_d = {6'b000000, clr_q, en_q};
                ADDR_STATUS: rd_data_d = status;
                ADDR_LEN:    rd_data_d = len_ext;
                ADDR_DATA: begin
                    rd_data_d = 8'h00;
                    if (valid_q) begin
                        if (rd_ptr_q < len_q) begin
                            rd_data_d = buf_rdata;
                            rd_ptr_d  = rd_ptr_q + 5'd1;
                        end
                        if (rd_ptr_q + 5'd1 >= len_q) begin
                            valid_d = 1'b0;
                        end
                    end
                end
            endcase
        end

        if (!en_q) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            if (bus.rx_en && bus.rx_data == SOF0) begin
                if (valid_q) begin
                    ovf_d = 1'b1;
                end else begin
                    state_d = S_HDR1;
                end
            end
        end else if (!bus.rx_en) begin
            err_gap_d = 1'b1;
            state_d   = S_IDLE;
        end else begin
            case (state_q)
                S_HDR1: begin
                    if (bus.rx_data == SOF1) begin
                        state_d = S_LENB;
                    end else if (bus.rx_data != SOF0) begin
                        state_d = S_IDLE;
                    end
                end
                S_LENB: begin
                    if (bus.rx_data > MAX_LEN_B) begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        rx_len_d = bus.rx_data[PTR_W-1:0];
                        wr_ptr_d = '0;
                        state_d  = (bus.rx_data == 8'h00) ? S_TRL0 : S_PAYLD;
                    end
                end
                S_PAYLD: begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 5'd1;
                    if (wr_ptr_q + 5'd1 == rx_len_q) begin
                        state_d = S_TRL0;
                    end
                end
                S_TRL0: begin
                    if (bus.rx_data == EOF0) begin
                        state_d = S_TRL1;
                    end else begin
                        err_trl_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                S_TRL1: begin
                    if (bus.rx_data == EOF1) begin
                        len_d        = rx_len_q;
                        valid_d      = 1'b1;
                        rd_ptr_d     = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        err_trl_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // clr acts on the cycle after the CTRL write and overrides any commit on that edge.
        if (clr_q) begin
            state_d      = S_IDLE;
            valid_d      = 1'b0;
            err_trl_d    = 1'b0;
            err_len_d    = 1'b0;
            err_gap_d    = 1'b0;
            ovf_d        = 1'b0;
            len_d        = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            frame_done_d = 1'b0;
            buf_we       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            en_q         <= 1'b0;
            clr_q        <= 1'b0;
            valid_q      <= 1'b0;
            err_trl_q    <= 1'b0;
            err_len_q    <= 1'b0;
            err_gap_q    <= 1'b0;
            ovf_q        <= 1'b0;
            len_q        <= '0;
            rx_len_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            clr_q        <= clr_d;
            valid_q      <= valid_d;
            err_trl_q    <= err_trl_d;
            err_len_q    <= err_len_d;
            err_gap_q    <= err_gap_d;
            ovf_q        <= ovf_d;
            len_q        <= len_d;
            rx_len_q     <= rx_len_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_data_q    <= rd_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the payload buffer is deliberately not reset; it is only readable while valid=1.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buffer[buf_waddr] <= bus.rx_data;
        end
    end

endmodule

// File: tb/tb_receive_dut.sv
// Randomized scoreboard bench for receive_dut: a frame-level model predicts register
// reads and commit counts; a monitor compares every read as the DUT presents it.
module tb_receive_dut;

    localparam int MAX_LEN = 16;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_LEN    = 2'd2;
    localparam logic [1:0] A_DATA   = 2'd3;

    localparam int K_GOOD = 0;
    localparam int K_DDE  = 1;
    localparam int K_TRL  = 2;
    localparam int K_LEN  = 3;
    localparam int K_GAP  = 4;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        logic [1:0] addr;
        logic [7:0] val;
    } rd_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    receive_dut_if bus ();

    receive_dut #(.MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         checks   = 0;
    int         errors   = 0;
    int         done_cnt = 0;
    logic       fd_prev  = 1'b0;
    logic [7:0] last_exp = 8'h00;
    rd_exp_t    exp_q[$];

    // Frame-level reference model
    logic       m_en, m_valid, m_trl, m_lenerr, m_gap, m_ovf;
    int         m_len;
    int         m_commits = 0;
    logic [7:0] m_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void m_clear();
        m_valid  = 1'b0;
        m_trl    = 1'b0;
        m_lenerr = 1'b0;
        m_gap    = 1'b0;
        m_ovf    = 1'b0;
        m_len    = 0;
        m_data.delete();
    endfunction

    function automatic void m_reset();
        m_en = 1'b0;
        m_clear();
    endfunction

    function automatic logic [7:0] m_status();
        return {3'b000, m_ovf, m_gap, m_lenerr, m_trl, m_valid};
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] a);
        logic [7:0] v;
        v = 8'h00;
        case (a)
            A_CTRL:   v = {7'b0000000, m_en};
            A_STATUS: v = m_status();
            A_LEN:    v = 8'(m_len);
            default: begin
                if (m_valid) begin
                    if (m_data.size() != 0) v = m_data.pop_front();
                    if (m_data.size() == 0) m_valid = 1'b0;
                end
            end
        endcase
        return v;
    endfunction

    // A start byte while a frame is still unread is an overrun; otherwise the frame's own outcome applies.
    function automatic void m_frame(input int kind, input bytes_t pl);
        if (m_valid) begin
            m_ovf = 1'b1;
            return;
        end
        case (kind)
            K_GOOD: begin
                m_valid = 1'b1;
                m_len   = pl.size();
                m_data  = pl;
                m_commits++;
            end
            K_TRL:   m_trl    = 1'b1;
            K_LEN:   m_lenerr = 1'b1;
            K_GAP:   m_gap    = 1'b1;
            default: ;
        endcase
    endfunction

    function automatic bytes_t build(input bytes_t pl);
        bytes_t b;
        b = '{8'hDE, 8'hAD, 8'(pl.size())};
        foreach (pl[i]) b.push_back(pl[i]);
        b.push_back(8'hBE);
        b.push_back(8'hEF);
        return b;
    endfunction

    function automatic bytes_t rand_payload(input int len);
        bytes_t p;
        for (int i = 0; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
        return p;
    endfunction

    task automatic step(input logic e, input logic [7:0] d, input logic w,
                        input logic [1:0] a, input logic [7:0] wd, input logic r);
        bus.rx_en   = e;
        bus.rx_data = d;
        bus.wr      = w;
        bus.addr    = a;
        bus.wr_data = wd;
        bus.rd      = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0, A_CTRL, 8'h00, 1'b0);
    endtask

    task automatic send(input bytes_t b);
        foreach (b[i]) step(1'b1, b[i], 1'b0, A_CTRL, 8'h00, 1'b0);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        step(1'b0, 8'h00, 1'b1, a, d, 1'b0);
        if (a == A_CTRL) begin
            m_en = d[0];
            if (d[1]) m_clear();
        end
        idle(1);
    endtask

    task automatic reg_read(input logic [1:0] a);
        rd_exp_t e;
        e.addr = a;
        e.val  = m_read(a);
        exp_q.push_back(e);
        step(1'b0, 8'h00, 1'b0, a, 8'h00, 1'b1);
    endtask

    task automatic drain();
        while (m_valid) reg_read(A_DATA);
    endtask

    task automatic frame(input int kind, input bytes_t pl);
        bytes_t     b;
        int         k;
        logic [7:0] v;
        b = build(pl);
        case (kind)
            K_TRL: begin
                k = b.size() - 1 - int'($urandom_range(0, 1));
                do v = 8'($urandom_range(0, 255)); while (v == b[k] || v == 8'hDE);
                b[k] = v;
            end
            K_LEN: b = '{8'hDE, 8'hAD, 8'($urandom_range(MAX_LEN + 1, 255))};
            K_GAP: begin
                k = int'($urandom_range(1, b.size() - 1));
                b = b[0:k-1];
            end
            K_DDE: b.push_front(8'hDE);
            default: ;
        endcase
        send(b);
        m_frame((kind == K_DDE) ? K_GOOD : kind, pl);
        idle(1 + int'($urandom_range(0, 2)));
    endtask

    task automatic check_done();
        idle(2);
        check("frame_done_count", done_cnt, m_commits);
    endtask

    // Read monitor: a read sampled at a rising edge is compared at the following falling edge.
    initial begin
        rd_exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1 && bus.rd === 1'b1) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got 0x%0h, expected no read", bus.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rd_data addr=%0d", e.addr), bus.rd_data, e.val);
                    last_exp = e.val;
                end
            end
        end
    end

    // frame_done monitor: counts pulses and flags any pulse wider than one cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin
                done_cnt++;
                check("frame_done_width", fd_prev, 1'b0);
            end
            fd_prev = bus.frame_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected simulation end");
        $fatal(1);
    end

    initial begin
        bytes_t pl_a;
        bytes_t pl_b;
        bytes_t b;
        int     act;

        bus.rx_en   = 1'b0;
        bus.rx_data = 8'h00;
        bus.wr      = 1'b0;
        bus.addr    = 2'd0;
        bus.wr_data = 8'h00;
        bus.rd      = 1'b0;
        m_reset();
        @(negedge clk);
        idle(3);
        rst_n = 1'b1;
        check("reset rd_data", bus.rd_data, 8'h00);
        check("reset frame_done", bus.frame_done, 1'b0);
        reg_read(A_CTRL);
        reg_read(A_STATUS);
        reg_read(A_LEN);
        reg_read(A_DATA);

        // Basic commit and readout
        reg_write(A_CTRL, 8'h01);
        pl_a = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        frame(K_GOOD, pl_a);
        check_done();
        reg_read(A_STATUS);
        reg_read(A_LEN);
        drain();
        reg_read(A_STATUS);
        idle(2);
        check("rd_data hold", bus.rd_data, last_exp);

        // Bad trailer
        b = build(pl_a);
        b[b.size() - 1] = 8'hEE;
        send(b);
        m_frame(K_TRL, pl_a);
        idle(1);
        reg_read(A_STATUS);
        reg_read(A_DATA);
        check_done();
        reg_write(A_CTRL, 8'h03);

        // Length over MAX_LEN, then a zero-length frame
        send('{8'hDE, 8'hAD, 8'h11});
        m_frame(K_LEN, pl_a);
        idle(1);
        reg_read(A_STATUS);
        frame(K_GOOD, '{});
        reg_read(A_STATUS);
        reg_read(A_LEN);
        check_done();
        reg_write(A_CTRL, 8'h03);

        // Gap after the third payload byte, then a good frame
        b = build(pl_a);
        b = b[0:5];
        send(b);
        m_frame(K_GAP, pl_a);
        idle(1);
        reg_read(A_STATUS);
        pl_b = rand_payload(7);
        frame(K_GOOD, pl_b);
        reg_read(A_STATUS);
        drain();
        check_done();
        reg_write(A_CTRL, 8'h03);

        // Overrun keeps the first payload intact
        frame(K_GOOD, pl_a);
        frame(K_GOOD, rand_payload(4));
        reg_read(A_STATUS);
        drain();
        reg_write(A_CTRL, 8'h03);
        reg_read(A_STATUS);
        check_done();

        // Repeated start byte in HDR1
        frame(K_DDE, rand_payload(3));
        reg_read(A_LEN);
        drain();

        // Disable mid-frame: abandoned with no error
        send('{8'hDE, 8'hAD, 8'h03});
        step(1'b1, 8'h11, 1'b1, A_CTRL, 8'h00, 1'b0);
        m_en = 1'b0;
        idle(2);
        reg_read(A_STATUS);
        reg_read(A_CTRL);
        reg_write(A_CTRL, 8'h01);

        // clr lands on the commit edge: no commit, no pulse
        send('{8'hDE, 8'hAD, 8'h02, 8'h5A, 8'hA5});
        step(1'b1, 8'hBE, 1'b1, A_CTRL, 8'h03, 1'b0);
        step(1'b1, 8'hEF, 1'b0, A_CTRL, 8'h00, 1'b0);
        m_clear();
        idle(1);
        reg_read(A_STATUS);
        reg_read(A_LEN);
        check_done();

        // Same-cycle CTRL read and write returns the pre-write value
        begin
            rd_exp_t e;
            reg_write(A_CTRL, 8'h00);
            e.addr = A_CTRL;
            e.val  = m_read(A_CTRL);
            exp_q.push_back(e);
            step(1'b0, 8'h00, 1'b1, A_CTRL, 8'h03, 1'b1);
            m_en = 1'b1;
            m_clear();
            idle(1);
            reg_read(A_CTRL);
        end

        // Reset during payload
        send('{8'hDE, 8'hAD, 8'h05, 8'h10, 8'h20});
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        m_reset();
        check("midframe reset rd_data", bus.rd_data, 8'h00);
        reg_read(A_STATUS);
        reg_write(A_CTRL, 8'h01);
        frame(K_GOOD, pl_a);
        reg_read(A_STATUS);
        drain();
        check_done();

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            act = int'($urandom_range(0, 12));
            case (act)
                0, 1, 2: frame(K_GOOD, rand_payload(int'($urandom_range(0, MAX_LEN))));
                3:       frame(K_DDE, rand_payload(int'($urandom_range(1, MAX_LEN))));
                4:       frame(K_TRL, rand_payload(int'($urandom_range(0, MAX_LEN))));
                5:       frame(K_LEN, '{});
                6:       frame(K_GAP, rand_payload(int'($urandom_range(0, MAX_LEN))));
                7:       reg_read(A_STATUS);
                8:       if ($urandom_range(0, 1) == 0) drain(); else reg_read(A_DATA);
                9:       reg_read(A_LEN);
                10:      reg_read(A_CTRL);
                11: begin
                    b.delete();
                    repeat (int'($urandom_range(1, 4))) begin
                        logic [7:0] v;
                        do v = 8'($urandom_range(0, 255)); while (v == 8'hDE);
                        b.push_back(v);
                    end
                    send(b);
                    idle(1);
                end
                default: reg_write(A_CTRL, 8'h03);
            endcase
        end
        reg_read(A_STATUS);
        reg_read(A_LEN);
        drain();
        check_done();

        idle(2);
        check("read queue drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
